// File: rtl/mips8_ctrl_fsm.sv
// rtl/mips8_ctrl_fsm.sv - multicycle 8-bit MIPS sequencing controller
// Moore control-word decode with a debug instruction counter; cycle-compatible with the PLA controller.
module mips8_ctrl_fsm #(
  parameter int ADDR_W       = 8,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic              zero,
  output logic              memread,
  output logic              memwrite,
  output logic              alusrca,
  output logic              memtoreg,
  output logic              iord,
  output logic              regwrite,
  output logic              regdst,
  output logic [1:0]        pcsource,
  output logic [1:0]        alusrcb,
  output logic [1:0]        aluop,
  output logic [3:0]        irwrite,
  output logic              pcen,
  output logic [3:0]        state,
  output logic              illegal,
  output logic [ADDR_W-1:0] dbg_cycles
);

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14,
    S_UNUSED  = 4'd15
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Plain vector register so every 4-bit code, including 15, is representable.
  logic [3:0] state_r;
  state_t     next_state;
  logic       undefined_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH1;
      dbg_cycles <= '0;
    end else begin
      state_r <= next_state;
      if (next_state == S_FETCH1) begin
        dbg_cycles <= dbg_cycles + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    next_state   = S_FETCH1;
    undefined_op = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    alusrca      = 1'b0;
    memtoreg     = 1'b0;
    iord         = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    pcsource     = 2'b00;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    irwrite      = 4'b0000;
    pcen         = 1'b0;

    case (state_r)
      S_FETCH1:  next_state = S_FETCH2;
      S_FETCH2:  next_state = S_FETCH3;
      S_FETCH3:  next_state = S_FETCH4;
      S_FETCH4:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_J:         next_state = S_JEX;
          OP_ADDI:      next_state = S_ADDIEX;
          default: begin
            next_state   = S_FETCH1;
            undefined_op = 1'b1;
          end
        endcase
      end
      // An opcode that is neither load nor store here abandons the instruction.
      S_MEMADR: begin
        if (op == OP_LB) begin
          next_state = S_LBRD;
        end else if (op == OP_SB) begin
          next_state = S_SBWR;
        end else begin
          next_state = S_FETCH1;
        end
      end
      S_LBRD:    next_state = S_LBWR;
      S_RTYPEEX: next_state = S_RTYPEWR;
      S_ADDIEX:  next_state = S_ADDIWR;
      default:   next_state = S_FETCH1;
    endcase

    // Control word; reset masks every strobe and select.
    if (!reset) begin
      case (state_r)
        S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = 4'b0001 << state_r[1:0];
          pcen    = 1'b1;
        end
        S_DECODE:  alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RTYPEWR: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        // zero only reaches pcen here, so an unknown flag elsewhere stays contained.
        S_BEQEX: begin
          alusrca  = 1'b1;
          aluop    = 2'b01;
          pcsource = 2'b01;
          pcen     = zero;
        end
        S_JEX: begin
          pcsource = 2'b10;
          pcen     = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWR:  regwrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = state_r;
  assign illegal = undefined_op && ILLEGAL_TRAP && !reset;

endmodule

// File: doc/mips8_ctrl_fsm.md
Name: mips8_ctrl_fsm

Overview:
- Sequencing controller for the 8-bit multicycle MIPS datapath.
- Holds the 4-bit state register and performs the next-state and control-word decode that the controller PLA implements in silicon.
- Drives all datapath enables and mux selects.
- Serves as the behavioural golden model and RTL replacement for the PLA-based controller, so the two can be compared cycle for cycle.

Parameters:
- ADDR_W, 8, width of datapath and memory address; only sizes `dbg_cycles`.
- ILLEGAL_TRAP, 1; 1: an undefined opcode in DECODE raises `illegal` and returns to FETCH1; 0: treated as NOP, no flag raised.

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instruction opcode from IR[31:26]
- zero  in  1  ALU zero flag, used for branches
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- memtoreg  out  1  register write data: 1 = MDR
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- regwrite  out  1  register file write enable
- regdst  out  1  destination register: 1 = rd, 0 = rt
- pcsource  out  2  PC mux: 00 ALU, 01 ALUOut, 10 jump
- alusrcb  out  2  ALU B: 00 B, 01 const 1, 10 imm, 11 imm (branch offset)
- aluop  out  2  00 add, 01 sub, 10 funct-decoded
- irwrite  out  4  one-hot byte enable into IR
- pcen  out  1  pcwrite OR (pcwritecond AND zero)
- state  out  4  current state code, for debug and PLA comparison
- illegal  out  1  one-cycle pulse on undefined opcode
- dbg_cycles  out  ADDR_W  free-running instruction counter, +1 per FETCH1 entry, wraps

Behaviour:
- State codes:
  - FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4
  - MEMADR=5, LBRD=6, LBWR=7, SBWR=8
  - RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12
  - ADDIEX=13, ADDIWR=14
  - 15 is unused; it always goes to FETCH1.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - DECODE branches on `op`:
    - 100000 (LB), 101000 (SB) → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 000010 → JEX
    - 001000 → ADDIEX
    - any other → FETCH1, with `illegal`=1 for that DECODE cycle when ILLEGAL_TRAP=1
  - MEMADR → LBRD if op=LB, SBWR if op=SB.
  - LBRD→LBWR→FETCH1.
  - SBWR→FETCH1.
  - RTYPEEX→RTYPEWR→FETCH1.
  - ADDIEX→ADDIWR→FETCH1.
  - BEQEX→FETCH1.
  - JEX→FETCH1.
- Outputs are Moore-decoded from `state` (combinational from the register). The only exception is `pcen`, which also depends on `zero` in BEQEX. Any output not listed for a state is 0.
  - FETCHn:
    - memread=1, alusrcb=01, aluop=00, pcsource=00
    - irwrite=1<<(n-1)
    - pcen=1 in every FETCH state (PC advances by 1 per byte)
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero.
  - JEX: pcsource=10, pcen=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- Instruction latency, counting FETCH1 through the last state:
  - LB = 8 cycles
  - SB, R-type, ADDI = 7
  - BEQ, J = 6
  - illegal = 5
- Reset:
  - Any rising edge with reset=1 loads state=FETCH1, dbg_cycles=0, illegal=0.
  - While reset is high, all strobes are forced to 0 regardless of state: memread, memwrite, regwrite, irwrite, pcen.
  - While reset is high, all selects are forced to 0.
  - The first cycle after reset deasserts is FETCH1 with full FETCH1 outputs.
  - Reset mid-instruction (e.g. during SBWR) abandons the instruction; there is no partial write on the reset cycle.
- `op` is sampled only in DECODE and MEMADR. `op` changing in other states has no effect.
- `zero` is used only in BEQEX. An X on `zero` elsewhere must not propagate to `pcen`.
- `dbg_cycles` increments on every transition into FETCH1, including from illegal and from state 15. It does not increment on reset entry. It wraps 255→0 at ADDR_W=8.

Test Plan:
- Reset then LB: reset=1 for 2 cycles, op=100000.
  - state sequence 0,1,2,3,4,5,6,7,0
  - irwrite 1,2,4,8 in cycles 1–4; iord=1 in state 6; memtoreg=1 and regwrite=1 in state 7
  - dbg_cycles=1 at return
- BEQ, op=000100:
  - zero=1: pcen=1 and pcsource=01 in state 11.
  - repeat with zero=0: pcen=0.
  - both cases return to state 0 after 6 cycles.
- SB then J back to back:
  - SB path 0–4,5,8 with memwrite=1 only in state 8.
  - J path 0–4,12 with pcsource=10 and pcen=1.
  - dbg_cycles advances by 2.
- Illegal op=111111, ILLEGAL_TRAP=1: illegal=1 for exactly one cycle in state 4, then state=0, no regwrite or memwrite asserted.
- Reset asserted in state 8 (SBWR): on that cycle memwrite=0; next state=0; dbg_cycles=0.
- Counter wrap: execute 256 J instructions → dbg_cycles returns to 0. Force state=15 → next state 0.
